// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM plus MMIO window (console TX FIFO,
// 64-bit cycle counter, halt register). Reads are combinational, writes commit on Clk.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TXF_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Dmem_addr,
  input  logic [1:0]  Dmem_write_en,
  input  logic [7:0]  Dmem_data_wr1,
  input  logic [7:0]  Dmem_data_wr2,
  input  logic [7:0]  Dmem_data_wr3,
  input  logic [7:0]  Dmem_data_wr4,
  output logic [31:0] Dmem_data_read,
  output logic [7:0]  Tx_data,
  output logic        Tx_valid,
  input  logic        Tx_ready,
  output logic        Halt,
  output logic [31:0] Halt_code,
  output logic        Misalign_err
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(TXF_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(TXF_DEPTH);

  localparam logic [3:0] REG_TX_DATA   = 4'h0;
  localparam logic [3:0] REG_TX_STATUS = 4'h1;
  localparam logic [3:0] REG_CYCLE_LO  = 4'h2;
  localparam logic [3:0] REG_CYCLE_HI  = 4'h3;
  localparam logic [3:0] REG_HALT      = 4'h4;

  logic [31:0]   mem [MEM_WORDS];
  logic [7:0]    txf [TXF_DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [63:0]   cycle_cnt;

  logic          ram_hit, mmio_hit, aligned;
  logic [AW-1:0] widx;
  logic [1:0]    boff;
  logic [3:0]    reg_sel;
  logic [3:0]    base_be, lane_be;
  logic [31:0]   lane_data, rd_word;
  logic          store_req, store_ok, misalign_set;
  logic          ram_we, tx_push, st_clr, halt_set;
  logic          full, empty, pop, push_ok;

  assign ram_hit  = Dmem_addr < RAM_BYTES;
  assign mmio_hit = Dmem_addr[31:6] == MMIO_BASE[31:6];
  assign widx     = Dmem_addr[AW+1:2];
  assign boff     = Dmem_addr[1:0];
  assign reg_sel  = Dmem_addr[5:2];

  always_comb begin
    aligned = 1'b0;
    base_be = 4'b0000;
    case (Dmem_write_en)
      2'b01: begin aligned = 1'b1;          base_be = 4'b0001; end
      2'b10: begin aligned = ~boff[0];      base_be = 4'b0011; end
      2'b11: begin aligned = (boff == 2'b00); base_be = 4'b1111; end
      default: ;
    endcase
  end

  // Alignment check guarantees the shifted lane mask never loses bits.
  assign lane_be   = base_be << boff;
  assign lane_data = {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} << {boff, 3'b000};

  assign store_req    = (Dmem_write_en != 2'b00) && !Halt && !Reset;
  assign store_ok     = store_req && aligned;
  assign misalign_set = store_req && !aligned;
  assign ram_we       = store_ok && ram_hit;
  assign tx_push      = store_ok && mmio_hit && (reg_sel == REG_TX_DATA);
  assign st_clr       = store_ok && mmio_hit && (reg_sel == REG_TX_STATUS);
  assign halt_set     = store_ok && mmio_hit && (reg_sel == REG_HALT) && (Dmem_write_en == 2'b11);

  always_ff @(posedge Clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[widx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && Tx_ready;
  assign push_ok = tx_push && (!full || pop);

  always_ff @(posedge Clk) begin
    if (push_ok) txf[wptr] <= Dmem_data_wr1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      if (st_clr)
        overflow <= 1'b0;
      else if (tx_push && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign Tx_valid = !empty;
  assign Tx_data  = empty ? 8'h00 : txf[rptr];

  // The store that raises Halt still sees Halt=0, so it is the last counted cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_cnt    <= '0;
      Halt         <= 1'b0;
      Halt_code    <= '0;
      Misalign_err <= 1'b0;
    end else begin
      if (!Halt) cycle_cnt <= cycle_cnt + 64'd1;
      if (halt_set) begin
        Halt      <= 1'b1;
        Halt_code <= {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1};
      end
      if (misalign_set) Misalign_err <= 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    if (ram_hit) begin
      rd_word = mem[widx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_TX_STATUS: rd_word = {29'b0, overflow, empty, full};
        REG_CYCLE_LO:  rd_word = cycle_cnt[31:0];
        REG_CYCLE_HI:  rd_word = cycle_cnt[63:32];
        default:       rd_word = '0;
      endcase
    end
  end

  assign Dmem_data_read = Reset ? '0 : (rd_word >> {boff, 3'b000});

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, misalign, TX FIFO, cycle counter, halt.
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Dmem_addr;
  logic [1:0]  Dmem_write_en;
  logic [7:0]  Dmem_data_wr1, Dmem_data_wr2, Dmem_data_wr3, Dmem_data_wr4;
  logic [31:0] Dmem_data_read;
  logic [7:0]  Tx_data;
  logic        Tx_valid;
  logic        Tx_ready;
  logic        Halt;
  logic [31:0] Halt_code;
  logic        Misalign_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.MEM_WORDS(1024), .TXF_DEPTH(8), .MMIO_BASE(MB)) dut (
    .Clk(Clk), .Reset(Reset),
    .Dmem_addr(Dmem_addr), .Dmem_write_en(Dmem_write_en),
    .Dmem_data_wr1(Dmem_data_wr1), .Dmem_data_wr2(Dmem_data_wr2),
    .Dmem_data_wr3(Dmem_data_wr3), .Dmem_data_wr4(Dmem_data_wr4),
    .Dmem_data_read(Dmem_data_read),
    .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready),
    .Halt(Halt), .Halt_code(Halt_code), .Misalign_err(Misalign_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    Dmem_addr     = a;
    Dmem_write_en = sz;
    {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = d;
    step();
    Dmem_write_en = 2'b00;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge Clk);
    Dmem_addr     = a;
    Dmem_write_en = 2'b00;
    #1;
    check(tag, {32'h0, Dmem_data_read}, {32'h0, exp});
  endtask

  logic [7:0] exp_q [8];

  initial begin
    Reset = 1'b1;
    Dmem_addr = '0;
    Dmem_write_en = 2'b00;
    {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = '0;
    Tx_ready = 1'b0;
    step();
    step();
    read_chk("rd_in_reset", 32'h0, 32'h0);
    check("rst_halt", {63'h0, Halt}, 64'h0);
    check("rst_code", {32'h0, Halt_code}, 64'h0);
    check("rst_misalign", {63'h0, Misalign_err}, 64'h0);
    check("rst_txvalid", {63'h0, Tx_valid}, 64'h0);
    check("rst_txdata", {56'h0, Tx_data}, 64'h0);
    Reset = 1'b0;
    repeat (100) step();
    read_chk("cycle_lo_100", MB + 32'h8, 32'd100);
    read_chk("cycle_hi_100", MB + 32'hC, 32'd0);
    read_chk("status_rst", MB + 32'h4, 32'h2);

    // RAM word store and shifted reads
    store(32'h0, 2'b11, 32'h11223344);
    read_chk("rd_w0", 32'h0, 32'h11223344);
    read_chk("rd_w0_off1", 32'h1, 32'h00112233);
    read_chk("rd_w0_off2", 32'h2, 32'h00001122);
    read_chk("rd_w0_off3", 32'h3, 32'h00000011);

    // Same-cycle write not visible until next cycle
    @(negedge Clk);
    Dmem_addr = 32'h0;
    Dmem_write_en = 2'b11;
    {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = 32'hAAAAAAAA;
    #1;
    check("same_cycle_old", {32'h0, Dmem_data_read}, {32'h0, 32'h11223344});
    step();
    Dmem_write_en = 2'b00;
    read_chk("next_cycle_new", 32'h0, 32'hAAAAAAAA);
    store(32'h0, 2'b11, 32'h11223344);

    // Byte and half stores into a preloaded word
    store(32'h4, 2'b11, 32'h99887766);
    store(32'h5, 2'b01, 32'h000000AB);
    store(32'h6, 2'b10, 32'h0000CDEF);
    read_chk("rd_w1_mixed", 32'h4, 32'hCDEFAB66);
    check("misalign_clean", {63'h0, Misalign_err}, 64'h0);

    // Misaligned stores write nothing and set the sticky flag
    store(32'h3, 2'b10, 32'h0000BEEF);
    check("misalign_half", {63'h0, Misalign_err}, 64'h1);
    store(32'h6, 2'b11, 32'hFFFFFFFF);
    read_chk("misalign_w0", 32'h0, 32'h11223344);
    read_chk("misalign_w1", 32'h4, 32'hCDEFAB66);

    // Unmapped and reserved MMIO
    store(32'h8000_0000, 2'b11, 32'h55555555);
    read_chk("unmapped", 32'h8000_0000, 32'h0);
    read_chk("mmio_rsvd", MB + 32'h14, 32'h0);
    read_chk("tx_data_rd", MB, 32'h0);

    // FIFO overflow then drain
    for (int i = 0; i < 9; i++) store(MB, 2'b01, 32'h41 + i);
    read_chk("status_full_ovf", MB + 32'h4, 32'h5);
    check("tx_head", {56'h0, Tx_data}, 64'h41);
    Tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), {55'h0, Tx_valid, Tx_data}, {55'h0, 1'b1, 8'h41 + 8'(i)});
      step();
    end
    Tx_ready = 1'b0;
    check("drained_valid", {63'h0, Tx_valid}, 64'h0);
    read_chk("status_empty_ovf", MB + 32'h4, 32'h6);
    store(MB + 32'h4, 2'b11, 32'h0);
    read_chk("status_ovf_clr", MB + 32'h4, 32'h2);
    check("misalign_sticky", {63'h0, Misalign_err}, 64'h1);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) store(MB, 2'b01, 32'h50 + i);
    read_chk("status_full", MB + 32'h4, 32'h1);
    Tx_ready = 1'b1;
    store(MB, 2'b01, 32'h5A);
    Tx_ready = 1'b0;
    read_chk("status_full_nopush_ovf", MB + 32'h4, 32'h1);
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h5A};
    Tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain%0d", i), {55'h0, Tx_valid, Tx_data}, {55'h0, 1'b1, exp_q[i]});
      step();
    end
    Tx_ready = 1'b0;
    check("pp_empty", {63'h0, Tx_valid}, 64'h0);

    // Reset with a partially drained FIFO
    for (int i = 0; i < 3; i++) store(MB, 2'b01, 32'h61 + i);
    Tx_ready = 1'b1;
    step();
    Tx_ready = 1'b0;
    check("partial_head", {56'h0, Tx_data}, 64'h62);
    Reset = 1'b1;
    step();
    check("midrst_valid", {63'h0, Tx_valid}, 64'h0);
    check("midrst_data", {56'h0, Tx_data}, 64'h0);
    check("midrst_misalign", {63'h0, Misalign_err}, 64'h0);
    Reset = 1'b0;

    // Halt: counter freezes at the halting store
    repeat (8) step();
    store(MB + 32'h10, 2'b01, 32'h000000FF);
    check("halt_byte_ign", {63'h0, Halt}, 64'h0);
    store(MB + 32'h10, 2'b10, 32'h0000FFFF);
    check("halt_half_ign", {63'h0, Halt}, 64'h0);
    store(MB + 32'h10, 2'b11, 32'hDEAD0001);
    check("halt_set", {63'h0, Halt}, 64'h1);
    check("halt_code", {32'h0, Halt_code}, {32'h0, 32'hDEAD0001});
    repeat (5) step();
    read_chk("cycle_frozen", MB + 32'h8, 32'd11);
    store(32'h0, 2'b11, 32'h12345678);
    read_chk("halt_ram_ign", 32'h0, 32'h11223344);
    store(MB, 2'b01, 32'h77);
    check("halt_tx_ign", {63'h0, Tx_valid}, 64'h0);
    store(MB + 32'h10, 2'b11, 32'h0BADF00D);
    check("halt_code_kept", {32'h0, Halt_code}, {32'h0, 32'hDEAD0001});

    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("post_rst_halt", {63'h0, Halt}, 64'h0);
    check("post_rst_code", {32'h0, Halt_code}, 64'h0);
    read_chk("post_rst_cycle", MB + 32'h8, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's Dmem interface (address, 2-bit write-size code, four byte write lanes, 32-bit read data).
- Provides a word-organised RAM plus a small MMIO window: console TX FIFO with a ready/valid drain port, a 64-bit cycle counter, and a halt register.
- Sits beside the core in the simulation top, in place of the ideal external data memory. Single-cycle: read data is valid in the same cycle as the address, and writes commit at the next rising edge.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- TXF_DEPTH, 8: TX FIFO depth in bytes; power of two, at least 2.
- MMIO_BASE, 32'hFFFF_0000: base byte address of the MMIO window; 64-byte aligned.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Dmem_addr  in  32  byte address from the core's memory stage.
- Dmem_write_en  in  2  write-size code: 00 none, 01 byte, 10 halfword, 11 word.
- Dmem_data_wr1  in  8  byte destined for address Addr.
- Dmem_data_wr2  in  8  byte destined for Addr+1.
- Dmem_data_wr3  in  8  byte destined for Addr+2.
- Dmem_data_wr4  in  8  byte destined for Addr+3.
- Dmem_data_read  out  32  combinational read data.
- Tx_data  out  8  head byte of the TX FIFO.
- Tx_valid  out  1  FIFO not empty.
- Tx_ready  in  1  console sink accepts Tx_data.
- Halt  out  1  sticky halt flag.
- Halt_code  out  32  value written to the HALT register.
- Misalign_err  out  1  sticky misaligned-store flag.

Behaviour:
- Reset:
  - Halt, Halt_code, Misalign_err, cycle counter, and TX overflow all clear to 0.
  - FIFO empty, so Tx_valid=0 and Tx_data=0.
  - Dmem_data_read is forced to 0 while Reset is high.
  - RAM contents are not reset; the bench preloads them.
- Address decode (A = Dmem_addr):
  - RAM when A < MEM_WORDS*4; word index A[log2(MEM_WORDS)+1:2].
  - MMIO when MMIO_BASE <= A < MMIO_BASE+64.
  - Anything else is unmapped: reads return 0, writes are ignored.
- Read:
  - Dmem_data_read = word at {A[31:2],2'b00} logically shifted right by 8*A[1:0]; the byte at A lands in [7:0] and vacated upper bytes are 0.
  - The core performs sign or zero extension.
  - Reads are combinational from current state. A write to the same word in the same cycle is not visible until the next cycle.
- Write:
  - Byte: lane wr1 is written to byte A.
  - Half: lanes wr1 and wr2 are written to A and A+1, only if A[0]=0.
  - Word: lanes wr1–wr4 are written to A..A+3, only if A[1:0]=0.
  - A misaligned half or word store writes nothing and sets Misalign_err (sticky until reset).
- MMIO map (offsets from MMIO_BASE); offsets 0x14–0x3C read 0 and ignore writes:
  - 0x00 TX_DATA: any write size pushes wr1 into the FIFO. If the FIFO is full and there is no same-cycle pop, the byte is dropped and overflow is set. Reads return 0.
  - 0x04 TX_STATUS: read {29'b0, overflow, empty, full}. Any write clears overflow.
  - 0x08 CYCLE_LO: read-only, counter[31:0].
  - 0x0C CYCLE_HI: read-only, counter[63:32]. Not snapshotted; software re-reads HI to detect wrap.
  - 0x10 HALT: a word store sets Halt=1 and Halt_code={wr4,wr3,wr2,wr1}. Byte and half stores to HALT are ignored.
- FIFO:
  - Circular buffer with read and write pointers and count 0..TXF_DEPTH.
  - Pop when Tx_valid && Tx_ready. Tx_data and Tx_valid are registered state (head entry), stable until popped.
  - Push and pop in the same cycle when full: both occur and count is unchanged.
  - Pointers wrap modulo TXF_DEPTH.
- Cycle counter:
  - Increments by 1 every cycle after reset while Halt=0.
  - Wraps at 2^64.
  - The write that sets Halt is the last increment cycle; the counter freezes thereafter.
- Halt:
  - Once Halt=1, all subsequent RAM and MMIO writes are ignored.
  - Reads and FIFO drain continue.
  - Reset asserted mid-operation (any cycle) clears all state above on the next edge, including a partially drained FIFO.

Test Plan:
- Word store 0x11223344 at 0x0, write_en=11, lanes 44/33/22/11 -> next cycle read at 0x0 returns 0x11223344; read at 0x2 returns 0x00001122.
- Byte store 0xAB at 0x5, then half store 0xCDEF at 0x6 -> read at 0x4 returns 0xCDEFAB??, with the low byte equal to the prior RAM content; Misalign_err stays 0.
- Half store at 0x3 and word store at 0x6 -> RAM unchanged and Misalign_err=1 on the next cycle; cleared only by Reset.
- Tx_ready=0, push 9 bytes 0x41..0x49 (TXF_DEPTH=8) -> TX_STATUS=0x5 (full, overflow); raise Tx_ready -> 0x41..0x48 drained in order, then Tx_valid=0 and TX_STATUS=0x6; write TX_STATUS -> reads 0x2.
- Fill FIFO, hold Tx_ready=1 and push 0x5A in the same cycle -> no overflow, count stays 8, 0x5A emerges last.
- Read CYCLE_LO after 100 cycles out of reset -> 100 (±stage offset); word store 0xDEAD0001 to HALT -> Halt=1, Halt_code=0xDEAD0001, counter frozen; a later RAM store is ignored; Reset clears Halt and the counter.
